spi_flash_ctrl: RTL and testbench
=================================

// Module: spi_flash_ctrl
// PURPOSE
//  Parametrised SPI NOR-flash master: controller FSM plus datapath in one block.
//  Serves single-word READ (0x03) and PAGE PROGRAM (0x02), issuing an automatic
//  WRITE ENABLE (0x06) before every program. Generic address/data width, SCK divider.
//  Sits between the core-side IO bus adapter and the off-chip flash pins.
// PARAMETERS
//  DATA_W   32  data word width in bits (multiple of 8, >=8)
//  ADDR_W   24  flash address width in bits (multiple of 8, >=8)
//  CLK_DIV  2   clk cycles per SCK half-period (>=1)
//  CS_GAP   2   clk cycles CS_n held high between WREN and PROGRAM frames (>=1)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       synchronous, active-low reset
//  start      in   1       request; sampled only in IDLE
//  wr         in   1       1 = program, 0 = read; latched with start
//  addr       in   ADDR_W  flash byte address; latched with start
//  writeData  in   DATA_W  program data; latched with start
//  readData   out  DATA_W  last completed read word
//  busy       out  1       high from cycle after accepted start through done cycle
//  done       out  1       one-cycle completion pulse
//  SCK        out  1       SPI clock, mode 0 (idle low)
//  CS_n       out  1       flash chip select, active low
//  DI         out  1       serial data to flash (MOSI)
//  DO         in   1       serial data from flash (MISO)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, SCK=0, CS_n=1, DI=0, busy=0, done=0,
//   readData=0, bit/div counters=0. Mid-transfer reset aborts at once; no done.
//  States: IDLE -> [wr] WREN -> GAP -> FRAME -> FIN -> IDLE
//                  [!wr] FRAME -> FIN -> IDLE
//  IDLE: start=1 latches wr/addr/writeData; next cycle CS_n=0, busy=1.
//   start while busy is ignored (no queueing).
//  Bit timing: each bit = 2*CLK_DIV clk cycles; SCK low first half, high second.
//   DI valid from first cycle of the bit (changes only while SCK low);
//   DO sampled on the clk edge where SCK rises. MSB first on all fields.
//  WREN: 8 bits of 0x06, then CS_n=1 for CS_GAP cycles (GAP), SCK=0, DI=0.
//  FRAME read : {0x03, addr} shifted out (8+ADDR_W bits), then DATA_W bits
//   shifted into the receive register from DO; DI=0 during data phase.
//  FRAME write: {0x02, addr, writeData} shifted out (8+ADDR_W+DATA_W bits).
//  FIN (1 cycle): CS_n=1, SCK=0, done=1; read copies receive reg to readData
//   in this cycle (readData stable otherwise; unchanged by writes/aborts).
//   busy falls the cycle after FIN; start may be accepted that same cycle.
//  Latency start-accept cycle -> done cycle inclusive of both:
//   read  = 2 + (8+ADDR_W+DATA_W)*2*CLK_DIV          (defaults: 258)
//   write = 2 + 16*CLK_DIV + CS_GAP + (8+ADDR_W+DATA_W)*2*CLK_DIV (defaults: 292)
//  Bit counter width = $clog2(8+ADDR_W+DATA_W+1); wraps never (cleared per frame).
//  When CS_n=1: SCK=0, DI=0. Inputs other than start/DO ignored while busy.
// TESTING
//  1 Reset held 3 cycles mid-read -> CS_n=1, SCK=0, busy=0, no done, readData kept.
//  2 Read addr=0x000100, flash model returns 0xDEADBEEF -> DI shows 0x03,0x000100;
//    done after 258 cycles, readData=0xDEADBEEF, 64 SCK rising edges.
//  3 Write addr=0x0000FF, writeData=0x12345678 -> frame 0x06, CS_n high 2 cycles,
//    frame 0x02,0x0000FF,0x12345678; done at cycle 292; readData unchanged.
//  4 start pulsed during busy -> ignored; exactly one done; next start accepted
//    the cycle after done -> CS_n falls one cycle later.
//  5 CLK_DIV=1, ADDR_W=16, DATA_W=8 read, model byte 0xA5 -> done at 2+32*2=66,
//    readData=0xA5.
//  6 Back-to-back read,write,read -> each done single-cycle; SCK idle low between.

Source files
------------

// File: rtl/spi_flash_ctrl.sv
// SPI NOR-flash master: single-word READ (0x03) and PAGE PROGRAM (0x02),
// with an automatic WRITE ENABLE (0x06) frame ahead of every program.
// SPI mode 0, MSB first; SCK half-period is CLK_DIV system clocks.
module spi_flash_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  output logic              SCK,
  output logic              CS_n,
  output logic              DI,
  input  logic              DO
);

  localparam int FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam int DIV_MAX = (2 * CLK_DIV > CS_GAP) ? 2 * CLK_DIV : CS_GAP;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);

  localparam logic [DIV_W-1:0] HALF      = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CS_GAP - 1);

  localparam logic [BIT_W-1:0] WREN_LAST_BIT  = BIT_W'(7);
  localparam logic [BIT_W-1:0] FRAME_LAST_BIT = BIT_W'(FRAME_W - 1);

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PROG = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_GAP,
    S_FRAME,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                sck_q, sck_d;
  logic                cs_n_q, cs_n_d;
  logic                di_q, di_d;

  logic bit_end;
  logic sample_pt;
  logic shifting_d;

  // State register plus all datapath and pin flops; reset aborts any transfer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      di_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      di_q        <= di_d;
    end
  end

  // Next-state, bit/divider sequencing and the registered pin values derived from it
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    bit_end   = (div_q == BIT_LAST);
    sample_pt = (div_q == HALF_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_d    = wr;
          addr_d  = addr;
          wdata_d = writeData;
          div_d   = '0;
          bit_d   = '0;
          if (wr) begin
            state_d = S_WREN;
            tx_d    = {CMD_WREN, {(FRAME_W - 8){1'b0}}};
          end else begin
            state_d = S_FRAME;
            tx_d    = {CMD_READ, addr, {DATA_W{1'b0}}};
          end
        end
      end

      S_WREN: begin
        if (bit_end) begin
          div_d = '0;
          tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
          if (bit_q == WREN_LAST_BIT) begin
            state_d = S_GAP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = S_FRAME;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = {CMD_PROG, addr_q, wdata_q};
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_FRAME: begin
        if (sample_pt) begin
          rx_d = {rx_q[DATA_W-2:0], DO};
        end
        if (bit_end) begin
          div_d = '0;
          tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
          if (bit_q == FRAME_LAST_BIT) begin
            state_d = S_FIN;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (!wr_q) begin
          read_data_d = rx_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    shifting_d = (state_d == S_WREN) || (state_d == S_FRAME);
    sck_d      = shifting_d && (div_d >= HALF);
    cs_n_d     = !shifting_d;
    di_d       = shifting_d ? tx_d[FRAME_W-1] : 1'b0;
  end

  assign readData = read_data_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign SCK      = sck_q;
  assign CS_n     = cs_n_q;
  assign DI       = di_q;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl: a behavioural flash model records each
// CS_n-framed MOSI stream and returns a programmable word on DO.
module tb_spi_flash_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        wr;
   logic [23:0] addr;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        busy;
   logic        done;
   logic        SCK;
   logic        CS_n;
   logic        DI;
   logic        DO;

   logic        start2;
   logic [15:0] addr2;
   logic [7:0]  readData2;
   logic        busy2;
   logic        done2;
   logic        sck2;
   logic        csN2;
   logic        di2;
   logic        do2;

   int total;
   int bad;

   // Flash model state for the default-parameter instance
   logic [31:0]  readResp;
   logic [127:0] mosiSh;
   int           riseCnt;
   logic [127:0] frameBits [32];
   int           frameLen  [32];
   int           frameCnt;
   int           doneTotal;

   // Flash model state for the narrow instance
   logic [7:0]   readResp2;
   logic [31:0]  mosiSh2;
   int           riseCnt2;

   spi_flash_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .wr        (wr),
      .addr      (addr),
      .writeData (writeData),
      .readData  (readData),
      .busy      (busy),
      .done      (done),
      .SCK       (SCK),
      .CS_n      (CS_n),
      .DI        (DI),
      .DO        (DO)
   );

   spi_flash_ctrl #(
      .DATA_W  (8),
      .ADDR_W  (16),
      .CLK_DIV (1),
      .CS_GAP  (2)
   ) dut2 (
      .clk       (clk),
      .rst       (rst),
      .start     (start2),
      .wr        (1'b0),
      .addr      (addr2),
      .writeData (8'h00),
      .readData  (readData2),
      .busy      (busy2),
      .done      (done2),
      .SCK       (sck2),
      .CS_n      (csN2),
      .DI        (di2),
      .DO        (do2)
   );

   // Free-running system clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flash shifts MOSI on each SCK rise and closes a frame when CS_n rises
   always @(posedge SCK or posedge CS_n) begin
      if (CS_n === 1'b1) begin
         if (riseCnt > 0) begin
            frameBits[frameCnt % 32] = mosiSh;
            frameLen[frameCnt % 32]  = riseCnt;
            frameCnt++;
         end
         riseCnt = 0;
         mosiSh  = '0;
      end else begin
         mosiSh = {mosiSh[126:0], DI};
         riseCnt++;
      end
   end

   // Flash presents the response word MSB first once command and address are in
   assign DO = (riseCnt >= 32 && riseCnt < 64) ? readResp[63 - riseCnt] : 1'b0;

   // Same flash behaviour for the narrow instance (8-bit command, 16-bit address)
   always @(posedge sck2 or posedge csN2) begin
      if (csN2 === 1'b1) begin
         riseCnt2 = 0;
      end else begin
         mosiSh2 = {mosiSh2[30:0], di2};
         riseCnt2++;
      end
   end

   assign do2 = (riseCnt2 >= 24 && riseCnt2 < 32) ? readResp2[31 - riseCnt2] : 1'b0;

   // Tally completion pulses away from the active edge
   always @(negedge clk) begin
      if (done === 1'b1) doneTotal++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Run one transaction; optionally pulse a conflicting start at cycle pulseAt
   task automatic applyStimulus(input logic isWrite, input logic [23:0] a, input logic [31:0] d,
                                input int pulseAt, output int lat, output int csHigh);
      @(negedge clk);
      checkOutput("idle_before_start", 64'(busy), 64'd0);
      start     = 1'b1;
      wr        = isWrite;
      addr      = a;
      writeData = d;
      lat       = 1;
      csHigh    = 0;
      @(negedge clk);
      start = 1'b0;
      lat   = 2;
      checkOutput("busy_rise", 64'(busy), 64'd1);
      checkOutput("cs_fall", 64'(CS_n), 64'd0);
      while (lat < 3000 && done !== 1'b1) begin
         @(negedge clk);
         lat++;
         if (lat == pulseAt) begin
            start     = 1'b1;
            wr        = ~isWrite;
            addr      = 24'h555555;
            writeData = 32'hFFFFFFFF;
         end else begin
            start = 1'b0;
         end
         if (done !== 1'b1 && CS_n === 1'b1) csHigh++;
      end
      start = 1'b0;
      checkOutput("done_seen", 64'(done), 64'd1);
      checkOutput("done_sck_idle", 64'(SCK), 64'd0);
      checkOutput("done_cs_high", 64'(CS_n), 64'd1);
   endtask

   int lat;
   int csHigh;
   int base;
   int dBase;

   initial begin
      total     = 0;
      bad       = 0;
      riseCnt   = 0;
      riseCnt2  = 0;
      mosiSh    = '0;
      mosiSh2   = '0;
      frameCnt  = 0;
      doneTotal = 0;
      readResp  = 32'h0;
      readResp2 = 8'hA5;
      rst       = 1'b0;
      start     = 1'b0;
      wr        = 1'b0;
      addr      = '0;
      writeData = '0;
      start2    = 1'b0;
      addr2     = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_cs", 64'(CS_n), 64'd1);
      checkOutput("rst_sck", 64'(SCK), 64'd0);
      checkOutput("rst_di", 64'(DI), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_readdata", 64'(readData), 64'd0);
      rst = 1'b1;

      $display("[TB] test 1: reset mid-read");
      readResp = 32'h11111111;
      dBase    = doneTotal;
      @(negedge clk);
      start = 1'b1;
      wr    = 1'b0;
      addr  = 24'h000100;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      checkOutput("mid_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("abort_cs", 64'(CS_n), 64'd1);
      checkOutput("abort_sck", 64'(SCK), 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", 64'(doneTotal - dBase), 64'd0);
      checkOutput("abort_readdata", 64'(readData), 64'd0);

      $display("[TB] test 2: read");
      readResp = 32'hDEADBEEF;
      base     = frameCnt;
      applyStimulus(1'b0, 24'h000100, 32'h0, 0, lat, csHigh);
      checkOutput("read_latency", 64'(lat), 64'd258);
      checkOutput("read_cs_gap", 64'(csHigh), 64'd0);
      @(negedge clk);
      checkOutput("read_busy_fall", 64'(busy), 64'd0);
      checkOutput("read_data", 64'(readData), 64'hDEADBEEF);
      checkOutput("read_frames", 64'(frameCnt - base), 64'd1);
      checkOutput("read_sck_edges", 64'(frameLen[base % 32]), 64'd64);
      checkOutput("read_mosi", frameBits[base % 32][63:0], 64'h0300010000000000);

      $display("[TB] test 3: write");
      base = frameCnt;
      applyStimulus(1'b1, 24'h0000FF, 32'h12345678, 0, lat, csHigh);
      checkOutput("write_latency", 64'(lat), 64'd292);
      checkOutput("write_cs_gap", 64'(csHigh), 64'd2);
      @(negedge clk);
      checkOutput("write_readdata_kept", 64'(readData), 64'hDEADBEEF);
      checkOutput("write_frames", 64'(frameCnt - base), 64'd2);
      checkOutput("wren_len", 64'(frameLen[base % 32]), 64'd8);
      checkOutput("wren_mosi", frameBits[base % 32][63:0], 64'h06);
      checkOutput("prog_len", 64'(frameLen[(base + 1) % 32]), 64'd64);
      checkOutput("prog_mosi", frameBits[(base + 1) % 32][63:0], 64'h020000FF12345678);

      $display("[TB] test 4/6: ignored start, back-to-back read/write/read");
      base     = frameCnt;
      dBase    = doneTotal;
      readResp = 32'hCAFEF00D;
      applyStimulus(1'b0, 24'h00ABCD, 32'h0, 20, lat, csHigh);
      checkOutput("b2b_read1_latency", 64'(lat), 64'd258);
      applyStimulus(1'b1, 24'h123456, 32'hA5A55A5A, 0, lat, csHigh);
      checkOutput("b2b_read1_data", 64'(readData), 64'hCAFEF00D);
      checkOutput("b2b_write_latency", 64'(lat), 64'd292);
      readResp = 32'h13579BDF;
      applyStimulus(1'b0, 24'h000010, 32'h0, 0, lat, csHigh);
      checkOutput("b2b_read2_latency", 64'(lat), 64'd258);
      @(negedge clk);
      checkOutput("b2b_read2_data", 64'(readData), 64'h13579BDF);
      checkOutput("b2b_frames", 64'(frameCnt - base), 64'd4);
      checkOutput("b2b_read1_mosi", frameBits[base % 32][63:0], 64'h0300ABCD00000000);
      checkOutput("b2b_prog_mosi", frameBits[(base + 2) % 32][63:0], 64'h02123456A5A55A5A);
      checkOutput("b2b_done_count", 64'(doneTotal - dBase), 64'd3);

      $display("[TB] test 5: narrow instance read");
      @(negedge clk);
      start2 = 1'b1;
      addr2  = 16'h1234;
      lat    = 1;
      @(negedge clk);
      start2 = 1'b0;
      lat    = 2;
      while (lat < 1000 && done2 !== 1'b1) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("narrow_done_seen", 64'(done2), 64'd1);
      checkOutput("narrow_latency", 64'(lat), 64'd66);
      checkOutput("narrow_mosi", 64'(mosiSh2), 64'h03123400);
      @(negedge clk);
      checkOutput("narrow_data", 64'(readData2), 64'hA5);
      checkOutput("narrow_busy_fall", 64'(busy2), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
